// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the decoded-instruction class bundle used by the
// pipeline control blocks.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_load;
    logic is_jump;
  } inst_class_t;

endpackage

// File: rtl/rv_inst_class.sv
// Combinational opcode classifier: which register fields an instruction reads
// and writes, and whether its result arrives late (load) or as a link (jump).
module rv_inst_class
  import rv32i_pkg::*;
(
  input  logic [31:0]  inst,
  output inst_class_t  cls
);

  logic [6:0] opcode;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign unused_fields = ^inst[31:7];

  // Unknown opcodes are treated as rs1 readers so a hazard is never missed.
  always_comb begin
    cls          = '0;
    cls.uses_rs1 = 1'b1;
    case (opcode)
      OPC_OP: begin
        cls.uses_rs2  = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OPC_OPIMM: cls.writes_rd = 1'b1;
      OPC_LOAD: begin
        cls.writes_rd = 1'b1;
        cls.is_load   = 1'b1;
      end
      OPC_STORE:  cls.uses_rs2 = 1'b1;
      OPC_BRANCH: cls.uses_rs2 = 1'b1;
      OPC_JAL: begin
        cls.uses_rs1  = 1'b0;
        cls.writes_rd = 1'b1;
        cls.is_jump   = 1'b1;
      end
      OPC_JALR: begin
        cls.writes_rd = 1'b1;
        cls.is_jump   = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        cls.uses_rs1  = 1'b0;
        cls.writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 3-stage F/X/W pipeline: slot
// occupancy, branch redirect/flush, load-use bubble, forwarding selects.
module pipe_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit LD_USE_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_X,
  input  logic [31:0]      inst_W,
  input  logic             br_taken_X,
  output logic             pc_F_sel,
  output logic             pc_en,
  output logic             hold_X,
  output logic             kill_X,
  output logic             kill_W,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  inst_class_t cls_x;
  inst_class_t cls_w;
  logic        valid_x;
  logic        valid_w;
  logic [4:0]  rd_w;
  logic [4:0]  rs1_x;
  logic [4:0]  rs2_x;
  logic        w_writes;
  logic        match_a;
  logic        match_b;
  logic [1:0]  w_src;
  logic        load_use;
  logic        redirect;

  rv_inst_class u_class_x (.inst(inst_X), .cls(cls_x));
  rv_inst_class u_class_w (.inst(inst_W), .cls(cls_w));

  assign rd_w  = inst_W[11:7];
  assign rs1_x = inst_X[19:15];
  assign rs2_x = inst_X[24:20];

  // Reset forces every hazard term off so the outputs are defined before the
  // first reset edge has cleared the slot state.
  assign w_writes = !rst && valid_w && cls_w.writes_rd && (rd_w != 5'd0);
  assign match_a  = w_writes && cls_x.uses_rs1 && (rs1_x == rd_w);
  assign match_b  = w_writes && cls_x.uses_rs2 && (rs2_x == rd_w);
  assign w_src    = (cls_w.is_load || cls_w.is_jump) ? FWD_WB : FWD_ALU;

  assign fwd_a_sel = match_a ? w_src : FWD_REG;
  assign fwd_b_sel = match_b ? w_src : FWD_REG;

  assign load_use = LD_USE_STALL && !rst && valid_x && valid_w && cls_w.is_load
                    && (match_a || match_b);
  assign redirect = !rst && valid_x && br_taken_X && !load_use;

  assign pc_F_sel = redirect;
  assign pc_en    = !load_use;
  assign hold_X   = load_use;
  assign kill_X   = rst || !valid_x;
  assign kill_W   = rst || !valid_w;

  // A stalled X instruction keeps its slot and replays; the W slot drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_x   <= 1'b0;
      valid_w   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (load_use) begin
      valid_w <= 1'b0;
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
    end else if (redirect) begin
      valid_x <= 1'b0;
      valid_w <= 1'b1;
      if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end else begin
      valid_x <= 1'b1;
      valid_w <= valid_x;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controller configurations share one stimulus stream
// and are checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LOAD = 7'h03, STORE = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63, JAL = 7'h6f, JALR = 7'h67;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, SYSTEM = 7'h73;
  localparam logic [31:0] I_NOP = 32'h0000_0013;

  typedef struct {
    int dut;
    logic pc_sel, pc_en, hold, kill_x, kill_w;
    logic [1:0] fa, fb;
    int st, fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] inst_x = I_NOP;
  logic [31:0] inst_w = I_NOP;
  logic br_taken = 1'b0;

  logic pc_sel [3];
  logic pc_en [3];
  logic hold [3];
  logic kill_x [3];
  logic kill_w [3];
  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic [15:0] st0, fl0, st1, fl1;
  logic [1:0] st2, fl2;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;

  bit m_vx [3];
  bit m_vw [3];
  int m_st [3];
  int m_fl [3];
  bit cfg_lus [3] = '{1'b1, 1'b0, 1'b1};
  int cfg_max [3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .LD_USE_STALL(1'b1)) dut0 (
    .clk(clk), .rst(rst), .inst_X(inst_x), .inst_W(inst_w), .br_taken_X(br_taken),
    .pc_F_sel(pc_sel[0]), .pc_en(pc_en[0]), .hold_X(hold[0]), .kill_X(kill_x[0]),
    .kill_W(kill_w[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .stall_cnt(st0), .flush_cnt(fl0));

  pipe_hazard_ctrl #(.CNT_W(16), .LD_USE_STALL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .inst_X(inst_x), .inst_W(inst_w), .br_taken_X(br_taken),
    .pc_F_sel(pc_sel[1]), .pc_en(pc_en[1]), .hold_X(hold[1]), .kill_X(kill_x[1]),
    .kill_W(kill_w[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .stall_cnt(st1), .flush_cnt(fl1));

  pipe_hazard_ctrl #(.CNT_W(2), .LD_USE_STALL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .inst_X(inst_x), .inst_W(inst_w), .br_taken_X(br_taken),
    .pc_F_sel(pc_sel[2]), .pc_en(pc_en[2]), .hold_X(hold[2]), .kill_X(kill_x[2]),
    .kill_W(kill_w[2]), .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]),
    .stall_cnt(st2), .flush_cnt(fl2));

  function automatic logic [31:0] mk(logic [6:0] opc, logic [4:0] rd, logic [4:0] rs1,
                                     logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, opc};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [10];
    logic [6:0] funct7;
    logic [2:0] funct3;
    opcs = '{OP, OPIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
    funct7 = 7'($urandom);
    funct3 = 3'($urandom);
    return {funct7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), funct3,
            5'($urandom_range(0, 3)), opcs[$urandom_range(0, 9)]};
  endfunction

  // Model of one cycle for every configuration: expected outputs come from the
  // current slot state, then the state advances by the stall/redirect rules.
  task automatic applyStimulus(input bit r, input logic [31:0] ix, input logic [31:0] iw,
                               input bit br);
    exp_t e;
    logic [4:0] rd, rs1, rs2;
    logic [6:0] ox, ow;
    bit w_wr, u1, u2, m1, m2, lu, redir;
    logic [1:0] src;
    rst = r;
    inst_x = ix;
    inst_w = iw;
    br_taken = br;
    rd = iw[11:7];
    rs1 = ix[19:15];
    rs2 = ix[24:20];
    ox = ix[6:0];
    ow = iw[6:0];
    w_wr = ow inside {OP, OPIMM, LUI, AUIPC, JAL, JALR, LOAD};
    u1 = !(ox inside {LUI, AUIPC, JAL});
    u2 = ox inside {OP, BRANCH, STORE};
    src = (ow inside {JAL, JALR, LOAD}) ? 2'd2 : 2'd1;
    for (int k = 0; k < 3; k++) begin
      m1 = !r && m_vw[k] && w_wr && rd != 0 && u1 && rs1 == rd;
      m2 = !r && m_vw[k] && w_wr && rd != 0 && u2 && rs2 == rd;
      lu = !r && cfg_lus[k] && m_vx[k] && m_vw[k] && ow == LOAD && (m1 || m2);
      redir = !r && m_vx[k] && br && !lu;
      e.dut = k;
      e.pc_sel = redir;
      e.pc_en = !lu;
      e.hold = lu;
      e.kill_x = r || !m_vx[k];
      e.kill_w = r || !m_vw[k];
      e.fa = m1 ? src : 2'd0;
      e.fb = m2 ? src : 2'd0;
      e.st = m_st[k];
      e.fl = m_fl[k];
      exp_q.push_back(e);
      if (r) begin
        m_vx[k] = 0; m_vw[k] = 0; m_st[k] = 0; m_fl[k] = 0;
      end else if (lu) begin
        m_vw[k] = 0;
        m_st[k] = (m_st[k] < cfg_max[k]) ? m_st[k] + 1 : m_st[k];
      end else if (redir) begin
        m_vx[k] = 0;
        m_vw[k] = 1;
        m_fl[k] = (m_fl[k] < cfg_max[k]) ? m_fl[k] + 1 : m_fl[k];
      end else begin
        m_vw[k] = m_vx[k];
        m_vx[k] = 1;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cycle,
                  act, expv);
  endtask

  task automatic checkOutput(input exp_t e);
    int k;
    logic [31:0] st, fl;
    k = e.dut;
    case (k)
      0: begin st = 32'(st0); fl = 32'(fl0); end
      1: begin st = 32'(st1); fl = 32'(fl1); end
      default: begin st = 32'(st2); fl = 32'(fl2); end
    endcase
    check("pc_F_sel", k, 32'(pc_sel[k]), 32'(e.pc_sel));
    check("pc_en", k, 32'(pc_en[k]), 32'(e.pc_en));
    check("hold_X", k, 32'(hold[k]), 32'(e.hold));
    check("kill_X", k, 32'(kill_x[k]), 32'(e.kill_x));
    check("kill_W", k, 32'(kill_w[k]), 32'(e.kill_w));
    check("fwd_a_sel", k, 32'(fa[k]), 32'(e.fa));
    check("fwd_b_sel", k, 32'(fb[k]), 32'(e.fb));
    check("stall_cnt", k, st, 32'(e.st));
    check("flush_cnt", k, fl, 32'(e.fl));
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    logic [31:0] lw_x5, add_x6, beq_56, jal_x1;
    lw_x5 = mk(LOAD, 5'd5, 5'd1, 5'd0);
    add_x6 = mk(OP, 5'd6, 5'd5, 5'd2);
    beq_56 = mk(BRANCH, 5'd0, 5'd5, 5'd6);
    jal_x1 = mk(JAL, 5'd1, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    // reset, then let both slots fill
    repeat (2) applyStimulus(1'b1, I_NOP, I_NOP, 1'b0);
    repeat (3) applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    // ALU forwarding, then rd = x0
    applyStimulus(1'b0, mk(OP, 5'd6, 5'd5, 5'd5), mk(OPIMM, 5'd5, 5'd0, 5'd7), 1'b0);
    applyStimulus(1'b0, mk(OP, 5'd6, 5'd0, 5'd0), mk(OPIMM, 5'd0, 5'd0, 5'd7), 1'b0);
    // load-use bubble and replay
    applyStimulus(1'b0, add_x6, lw_x5, 1'b0);
    applyStimulus(1'b0, add_x6, I_NOP, 1'b0);
    applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    // taken branch, pulse during the bubble, then refill
    applyStimulus(1'b0, beq_56, I_NOP, 1'b1);
    applyStimulus(1'b0, beq_56, I_NOP, 1'b1);
    applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    // load-use coinciding with a taken branch
    applyStimulus(1'b0, beq_56, lw_x5, 1'b1);
    applyStimulus(1'b0, beq_56, I_NOP, 1'b1);
    applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    // back-to-back load-use pairs drive the narrow counter into saturation
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, add_x6, lw_x5, 1'b0);
      applyStimulus(1'b0, add_x6, lw_x5, 1'b0);
    end
    applyStimulus(1'b0, mk(OPIMM, 5'd2, 5'd1, 5'd4), jal_x1, 1'b0);
    applyStimulus(1'b0, I_NOP, I_NOP, 1'b0);
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom_range(0, 63) == 0), rand_inst(), rand_inst(),
                    ($urandom_range(0, 2) == 0));
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
